// File: rtl/dac_sample_scheduler_if.sv
// Producer strobes/samples in, one valid/ready sample port out, per-requester overrun pulses.
// overrun_count is only present when SAMPLE_SCHED_OVERRUN_CNT_EN is defined.
interface dac_sample_scheduler_if #(
  parameter int NUM_REQ      = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int ID_WIDTH     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ*SAMPLE_WIDTH-1:0] req_sample;
  logic                            out_ready;
  logic                            out_valid;
  logic signed [SAMPLE_WIDTH-1:0]  out_sample;
  logic [ID_WIDTH-1:0]             out_id;
  logic [NUM_REQ-1:0]              overrun;
`ifdef SAMPLE_SCHED_OVERRUN_CNT_EN
  logic [NUM_REQ*8-1:0]            overrun_count;

  modport master (
    output req_valid, req_sample, out_ready,
    input  out_valid, out_sample, out_id, overrun, overrun_count
  );
  modport slave (
    input  req_valid, req_sample, out_ready,
    output out_valid, out_sample, out_id, overrun, overrun_count
  );
`else
  modport master (
    output req_valid, req_sample, out_ready,
    input  out_valid, out_sample, out_id, overrun
  );
  modport slave (
    input  req_valid, req_sample, out_ready,
    output out_valid, out_sample, out_id, overrun
  );
`endif
endinterface

// File: rtl/dac_sample_scheduler.sv
// Round-robin share of one DAC sample path: strobe->offer in 2 cycles, offer held until out_ready, then GAP_CYCLES idle.
// Defining SAMPLE_SCHED_OVERRUN_CNT_EN adds saturating 8-bit per-requester overrun counters.
module dac_sample_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int GAP_CYCLES   = 4,
  parameter int ID_WIDTH     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  dac_sample_scheduler_if.slave bus
);
  localparam int IW1 = ID_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, OFFER, GAP} state_t;

  state_t                  state_q, state_d;
  logic [NUM_REQ-1:0]      pending;
  logic [SAMPLE_WIDTH-1:0] slot [NUM_REQ];
  logic [ID_WIDTH-1:0]     last_grant, grant_id, out_id_q;
  logic [7:0]              gap_cnt;
  logic                    out_valid_q;
  logic [SAMPLE_WIDTH-1:0] out_sample_q;
  logic [NUM_REQ-1:0]      overrun_q, grant_vec;
  logic                    grant_found, grant_en, accept;

  // First pending slot after last_grant, wrapping modulo NUM_REQ.
  always_comb begin
    logic [IW1-1:0] idx;
    grant_id    = '0;
    grant_found = 1'b0;
    idx         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, last_grant} + IW1'(k);
      if (idx >= IW1'(NUM_REQ))
        idx = idx - IW1'(NUM_REQ);
      if (!grant_found && pending[idx[ID_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = idx[ID_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          grant_en = 1'b1;
          state_d  = OFFER;
        end
      end
      OFFER: begin
        if (bus.out_ready) begin
          accept  = 1'b1;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt <= 8'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_vec = grant_en ? (NUM_REQ'(1) << grant_id) : '0;

  // A strobe coinciding with the grant of its own slot refills it rather than overrunning.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      overrun_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        overrun_q[i] <= bus.req_valid[i] & pending[i] & ~grant_vec[i];
        if (bus.req_valid[i]) begin
          slot[i]    <= bus.req_sample[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
          pending[i] <= 1'b1;
        end else if (grant_vec[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      out_id_q     <= '0;
      last_grant   <= ID_WIDTH'(NUM_REQ - 1);
      gap_cnt      <= '0;
    end else begin
      if (grant_en) begin
        out_valid_q  <= 1'b1;
        out_sample_q <= slot[grant_id];
        out_id_q     <= grant_id;
      end else if (accept) begin
        out_valid_q  <= 1'b0;
        last_grant   <= out_id_q;
      end
      if (accept)
        gap_cnt <= 8'(GAP_CYCLES);
      else if (state_q == GAP)
        gap_cnt <= gap_cnt - 8'd1;
    end
  end

`ifdef SAMPLE_SCHED_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt [NUM_REQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) ovr_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (overrun_q[i] && ovr_cnt[i] != 8'hff) ovr_cnt[i] <= ovr_cnt[i] + 8'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign bus.overrun_count[g*8 +: 8] = ovr_cnt[g];
  end
`endif

  assign bus.out_valid  = out_valid_q;
  assign bus.out_sample = out_sample_q;
  assign bus.out_id     = out_id_q;
  assign bus.overrun    = overrun_q;
endmodule
